// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder: captures an N-bit request vector and emits the index of
// every set bit, one per beat, in priority order, with valid/ready handshakes
// on both sides.
// Optional feature: define PRIO_SCAN_LAST_EN to add the out_last port, which
// marks the final beat of a vector.
module prio_scan_encoder #(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout,
`ifdef PRIO_SCAN_LAST_EN
    output logic         out_last,
`endif
    output logic         zero_flag
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic           zero_q, zero_d;

    logic [W-1:0]   sel_idx;
    logic [N-1:0]   pend_clr;
    logic           capture;

    // Priority select over the registered pending vector; the last hit wins.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(N); i++) begin
                if (pend_q[i]) sel_idx = W'(i);
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (pend_q[i]) sel_idx = W'(i);
            end
        end
    end

    // Pending vector with the currently presented bit retired.
    always_comb begin
        pend_clr = pend_q & ~(N'(1) << sel_idx);
    end

    // Handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StScan);
        dout      = sel_idx;
        zero_flag = zero_q;
        capture   = en && in_valid && in_ready;
    end

`ifdef PRIO_SCAN_LAST_EN
    // Final beat: exactly one pending bit remains.
    always_comb begin
        out_last = out_valid && (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);
    end
`endif

    // Next-state logic: capture in idle, retire one bit per accepted beat.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zero_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    pend_d = din;
                    if (din != '0) begin
                        state_d = StScan;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            StScan: begin
                if (out_ready) begin
                    pend_d = pend_clr;
                    if (pend_clr == '0) state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                pend_d  = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pend_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zero_q  <= zero_d;
        end
    end

endmodule
